// File: rtl/aud_pkg.sv
// Shared types and constants for the audio player: FSM state, speed field decode,
// I2S slot width and the Q1.15 reciprocal table used by slow-play interpolation.
package aud_pkg;

    // Bits shifted out per I2S channel slot
    localparam int unsigned I2S_WORD_W = 16;

    // i_speed decode: [3] selects slow play, [2:0]+1 is the factor F
    localparam int unsigned SPEED_SLOW_BIT = 3;
    localparam int unsigned SPEED_FACT_W   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StPlaying,
        StPaused
    } player_state_e;

    // Q1.15 value of 1/F, indexed by F-1
    function automatic logic [15:0] recip_q15(input logic [SPEED_FACT_W-1:0] idx);
        logic [15:0] r;
        case (idx)
            3'd0:    r = 16'd32767;
            3'd1:    r = 16'd16384;
            3'd2:    r = 16'd10923;
            3'd3:    r = 16'd8192;
            3'd4:    r = 16'd6554;
            3'd5:    r = 16'd5461;
            3'd6:    r = 16'd4681;
            default: r = 16'd4096;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aud_i2s_serializer.sv
// I2S DACDAT serializer: detects LRC edges, loads a parallel word on request and
// shifts it out MSB-first, one bit per cycle, then holds the line low until the
// next load. A clear forces the line low and abandons the current slot.
module aud_i2s_serializer
    import aud_pkg::*;
#(
    parameter int unsigned DATA_W = I2S_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_edge,
    output logic              o_fall,
    output logic              o_dacdat
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic              prev_lrc_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dacdat_q, dacdat_d;

    assign o_edge   = i_lrc ^ prev_lrc_q;
    assign o_fall   = o_edge & ~i_lrc;
    assign o_dacdat = dacdat_q;

    // Shift/count next state; the MSB goes straight to the output register on load
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        dacdat_d = 1'b0;
        if (i_clear) begin
            cnt_d = CNT_W'(DATA_W);
        end else if (i_load) begin
            dacdat_d = i_word[DATA_W-1];
            shift_d  = i_word << 1;
            cnt_d    = CNT_W'(1);
        end else if (cnt_q < CNT_W'(DATA_W)) begin
            dacdat_d = shift_q[DATA_W-1];
            shift_d  = shift_q << 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Serializer state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_lrc_q <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            dacdat_q   <= 1'b0;
        end else begin
            prev_lrc_q <= i_lrc;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            dacdat_q   <= dacdat_d;
        end
    end

endmodule

// File: rtl/aud_player_i2s.sv
// SRAM-to-WM8731 I2S playback engine running on (inverted) BCLK.
// IDLE/PLAYING/PAUSED control, SRAM read address generation with fast play
// (address skip) and slow play (frame repeat). A new sample is fetched at each
// falling LRC edge and sent in both the left and right slots.
// Build option: define AUD_PLAYER_INTERP_EN to replace slow-play repeats with
// linear interpolation between the previous and current sample.
module aud_player_i2s
    import aud_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic [ADDR_W-1:0] o_address,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic              o_dacdat,
    output logic              o_playing,
    output logic              o_done
);

    player_state_e state_q, state_d;

    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [SPEED_FACT_W-1:0] rep_q, rep_d;
    logic [3:0]              speed_q, speed_d;
    logic [DATA_W-1:0]       sample_q, sample_d;
    logic                    end_pend_q, end_pend_d;
    logic                    done_q, done_d;

    logic              lrc_edge, lrc_fall, at_end;
    logic              ser_load, ser_clear;
    logic [DATA_W-1:0] ser_word, fall_word;
    logic [ADDR_W:0]   step_w, next_addr;
    logic              advance;

`ifdef AUD_PLAYER_INTERP_EN
    localparam int unsigned PROD_W = (DATA_W + 1) + (SPEED_FACT_W + 1) + 17;

    logic [DATA_W-1:0]        prev_samp_q, prev_samp_d;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_x, k_x, recip_x, prod;
    logic [DATA_W-1:0]        interp;
`endif

    // End of data is acted on at the falling LRC edge after the last frame
    assign at_end = (state_q == StPlaying) && lrc_fall && end_pend_q;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stop > end of data > pause > start
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!i_stop && i_start) state_d = StPlaying;
            end
            StPlaying: begin
                if (i_stop || at_end) state_d = StIdle;
                else if (i_pause)     state_d = StPaused;
            end
            StPaused: begin
                if (i_stop)        state_d = StIdle;
                else if (i_pause)  state_d = StPaused;
                else if (i_start)  state_d = StPlaying;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: serializer runs only while staying in PLAYING
    always_comb begin
        o_playing = (state_q == StPlaying);
        ser_clear = (state_d != StPlaying);
        ser_load  = lrc_edge && (state_q == StPlaying) && (state_d == StPlaying);
    end

`ifdef AUD_PLAYER_INTERP_EN
    // prev + ((cur - prev) * k * (1/F)) >>> 15, with k the repeat index
    always_comb begin
        diff    = $signed({i_sram_data[DATA_W-1], i_sram_data})
                - $signed({prev_samp_q[DATA_W-1], prev_samp_q});
        diff_x  = PROD_W'(diff);
        k_x     = PROD_W'(rep_q);
        recip_x = PROD_W'(recip_q15(speed_q[SPEED_FACT_W-1:0]));
        prod    = diff_x * k_x * recip_x;
        interp  = prev_samp_q + DATA_W'(prod >>> 15);
    end
`endif

    // Word for the slot about to start: fresh SRAM word on the left, held word on the right
    always_comb begin
        fall_word = i_sram_data;
`ifdef AUD_PLAYER_INTERP_EN
        if (speed_q[SPEED_SLOW_BIT]) fall_word = interp;
`endif
        ser_word = lrc_fall ? fall_word : sample_q;
    end

    // Address, repeat, speed and end-of-data next state
    always_comb begin
        addr_d     = addr_q;
        rep_d      = rep_q;
        speed_d    = speed_q;
        sample_d   = sample_q;
        end_pend_d = end_pend_q;
        done_d     = 1'b0;
        advance    = 1'b0;
`ifdef AUD_PLAYER_INTERP_EN
        prev_samp_d = prev_samp_q;
`endif
        step_w    = speed_q[SPEED_SLOW_BIT] ? (ADDR_W+1)'(1)
                  : (ADDR_W+1)'(speed_q[SPEED_FACT_W-1:0]) + (ADDR_W+1)'(1);
        next_addr = {1'b0, addr_q} + step_w;

        if (state_d == StIdle) begin
            addr_d     = '0;
            rep_d      = '0;
            end_pend_d = 1'b0;
            done_d     = at_end && !i_stop;
`ifdef AUD_PLAYER_INTERP_EN
            prev_samp_d = '0;
`endif
        end else begin
            if ((state_d == StPlaying) && (state_q != StPlaying)) begin
                speed_d = i_speed;
            end
            if ((state_q == StPlaying) && (state_d == StPlaying) && lrc_fall) begin
                sample_d = fall_word;
                if (!speed_q[SPEED_SLOW_BIT]) begin
                    advance = 1'b1;
                end else if (rep_q == speed_q[SPEED_FACT_W-1:0]) begin
                    rep_d   = '0;
                    advance = 1'b1;
                end else begin
                    rep_d = rep_q + 3'd1;
                end
                if (advance) begin
`ifdef AUD_PLAYER_INTERP_EN
                    prev_samp_d = i_sram_data;
`endif
                    // Carry out of ADDR_W bits also lands here
                    if (next_addr > {1'b0, i_end_addr}) begin
                        end_pend_d = 1'b1;
                    end else begin
                        addr_d = next_addr[ADDR_W-1:0];
                    end
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q     <= '0;
            rep_q      <= '0;
            speed_q    <= '0;
            sample_q   <= '0;
            end_pend_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef AUD_PLAYER_INTERP_EN
            prev_samp_q <= '0;
`endif
        end else begin
            addr_q     <= addr_d;
            rep_q      <= rep_d;
            speed_q    <= speed_d;
            sample_q   <= sample_d;
            end_pend_q <= end_pend_d;
            done_q     <= done_d;
`ifdef AUD_PLAYER_INTERP_EN
            prev_samp_q <= prev_samp_d;
`endif
        end
    end

    assign o_address = addr_q;
    assign o_done    = done_q;

    aud_i2s_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_lrc    (i_lrc),
        .i_load   (ser_load),
        .i_clear  (ser_clear),
        .i_word   (ser_word),
        .o_edge   (lrc_edge),
        .o_fall   (lrc_fall),
        .o_dacdat (o_dacdat)
    );

endmodule

// File: tb/tb_aud_player_i2s.sv
// Directed bench for aud_player_i2s: LRC generated with 32 BCLK per slot,
// combinational SRAM model, all expected words/addresses written out by hand.
module tb_aud_player_i2s;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int          SLOT   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              lrc, start, pause, stop;
    logic [3:0]        speed;
    logic [ADDR_W-1:0] end_addr, address;
    logic [DATA_W-1:0] sram_data;
    logic              dacdat, playing, done;

    logic [15:0] mem [32];
    int          slot_cnt;
    logic        toggled;
    int          errs   = 0;
    int          checks = 0;
    logic [15:0] word;

    always #5 clk = ~clk;

    assign sram_data = mem[address[4:0]];

    aud_player_i2s #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_lrc       (lrc),
        .i_start     (start),
        .i_pause     (pause),
        .i_stop      (stop),
        .i_speed     (speed),
        .i_end_addr  (end_addr),
        .o_address   (address),
        .i_sram_data (sram_data),
        .o_dacdat    (dacdat),
        .o_playing   (playing),
        .o_done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One BCLK; inputs and samples happen 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        toggled = 1'b0;
        slot_cnt++;
        if (slot_cnt == SLOT) begin
            slot_cnt = 0;
            lrc      = ~lrc;
            toggled  = 1'b1;
        end
    endtask

    // Returns in the cycle the DUT sees as the LRC edge cycle
    task automatic wait_toggle(input logic v);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(toggled && lrc == v) && n < 200);
        if (n >= 200) check_val("lrc_wait_bound", 32'(n), 32'd0);
    endtask

    task automatic grab(output logic [15:0] w);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            w = {w[14:0], dacdat};
        end
    endtask

    task automatic start_at_rise();
        wait_toggle(1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_basic();
        mem[0] = 16'hA5C3;
        mem[1] = 16'h0001;
        mem[2] = 16'h8000;
        mem[3] = 16'h7FFF;
    endtask

    logic [15:0] slow_exp [6];
    int          slow_addr [6] = '{0, 0, 1, 1, 1, 1};

    initial begin
        lrc = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        speed = 4'b0000; end_addr = 20'd3;
        slot_cnt = 0; toggled = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        load_basic();
`ifdef AUD_PLAYER_INTERP_EN
        slow_exp = '{16'd0, 16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
`else
        slow_exp = '{16'd300, 16'd300, 16'd300, 16'd600, 16'd600, 16'd600};
`endif

        // Reset state
        repeat (3) step();
        check_val("rst_addr", 32'(address), 32'd0);
        check_val("rst_dac", 32'(dacdat), 32'd0);
        check_val("rst_play", 32'(playing), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Normal speed, end at address 3
        start_at_rise();
        check_val("n_play", 32'(playing), 32'd1);
        for (int w = 0; w < 4; w++) begin
            wait_toggle(1'b0);
            check_val("n_gap", 32'(dacdat), 32'd0);
            grab(word);
            check_val("n_left", 32'(word), 32'(mem[w]));
            check_val("n_addr", 32'(address), (w < 3) ? 32'(w + 1) : 32'd3);
            wait_toggle(1'b1);
            grab(word);
            check_val("n_right", 32'(word), 32'(mem[w]));
        end
        wait_toggle(1'b0);
        check_val("n_done_early", 32'(done), 32'd0);
        step();
        check_val("n_done", 32'(done), 32'd1);
        check_val("n_end_play", 32'(playing), 32'd0);
        check_val("n_end_addr", 32'(address), 32'd0);
        step();
        check_val("n_done_once", 32'(done), 32'd0);
        check_val("n_end_dac", 32'(dacdat), 32'd0);

        // Fast x4, end at 20; speed change while playing must be ignored
        for (int i = 0; i < 32; i++) mem[i] = 16'(16'h1000 + i * 16'h0111);
        end_addr = 20'd20;
        speed    = 4'b0011;
        start_at_rise();
        speed = 4'b0000;
        for (int j = 0; j < 6; j++) begin
            wait_toggle(1'b0);
            grab(word);
            check_val("fast_word", 32'(word), 32'(mem[4 * j]));
            check_val("fast_addr", 32'(address), (j < 5) ? 32'(4 * j + 4) : 32'd20);
        end
        wait_toggle(1'b0);
        step();
        check_val("fast_done", 32'(done), 32'd1);
        check_val("fast_idle_addr", 32'(address), 32'd0);

        // Slow x3, end at 1
        mem[0]   = 16'd300;
        mem[1]   = 16'd600;
        end_addr = 20'd1;
        speed    = 4'b1010;
        start_at_rise();
        for (int j = 0; j < 6; j++) begin
            wait_toggle(1'b0);
            grab(word);
            check_val("slow_word", 32'(word), 32'(slow_exp[j]));
            check_val("slow_addr", 32'(address), 32'(slow_addr[j]));
        end
        wait_toggle(1'b0);
        step();
        check_val("slow_done", 32'(done), 32'd1);

        // Pause mid-slot, resume at next edge, start+stop while paused
        load_basic();
        end_addr = 20'd3;
        speed    = 4'b0000;
        start_at_rise();
        wait_toggle(1'b0);
        repeat (2) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        check_val("pause_dac", 32'(dacdat), 32'd0);
        check_val("pause_play", 32'(playing), 32'd0);
        check_val("pause_addr", 32'(address), 32'd1);
        repeat (3) step();
        check_val("pause_hold", 32'(address), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("resume_play", 32'(playing), 32'd1);
        check_val("resume_midslot", 32'(dacdat), 32'd0);
        wait_toggle(1'b1);
        grab(word);
        check_val("resume_word", 32'(word), 32'hA5C3);
        wait_toggle(1'b0);
        grab(word);
        check_val("resume_next", 32'(word), 32'h0001);
        check_val("resume_addr", 32'(address), 32'd2);
        pause = 1'b1;
        step();
        pause = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check_val("prio_play", 32'(playing), 32'd0);
        check_val("prio_addr", 32'(address), 32'd0);

        // Async reset between edges
        start_at_rise();
        wait_toggle(1'b0);
        step();
        check_val("arst_pre_dac", 32'(dacdat), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_dac", 32'(dacdat), 32'd0);
        check_val("arst_play", 32'(playing), 32'd0);
        check_val("arst_addr", 32'(address), 32'd0);
        step();
        rst = 1'b0;
        start_at_rise();
        wait_toggle(1'b0);
        grab(word);
        check_val("arst_restart", 32'(word), 32'hA5C3);
        check_val("arst_rs_addr", 32'(address), 32'd1);

        // Stop mid-slot
        wait_toggle(1'b1);
        repeat (2) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("stop_dac", 32'(dacdat), 32'd0);
        check_val("stop_play", 32'(playing), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
